// File: rtl/aes128_decrypt_iter.sv
// rtl/aes128_decrypt_iter.sv - iterative AES-128 decryption core, one inverse round per clock
module aes128_decrypt_iter (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         v_i,
  output logic         ready_o,
  input  logic [127:0] ciphertext_i,
  input  logic [127:0] key_i,
  output logic         v_o,
  input  logic         ready_i,
  output logic [127:0] plaintext_o
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state;
  logic [127:0] ct;
  logic [127:0] rk [0:10];
  logic [3:0]   cnt;

  logic [3:0]   kidx;
  logic [127:0] rk_new;
  logic [127:0] round_ark;
  logic [127:0] round_full;

  // GF(2^8) multiply, reduction polynomial 0x11b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-box table, derived from inverse plus affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse S-box table: inverse affine map, then field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte k sits at row k%4, column k/4; row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Round datapath: next round key during KEXP, inverse round during DEC
  always_comb begin
    kidx       = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    rk_new     = key_next(rk[kidx], rcon(cnt));
    round_ark  = inv_sub_bytes(inv_shift_rows(state)) ^ rk[cnt];
    round_full = inv_mix_columns(round_ark);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) fsm_q <= IDLE;
    else            fsm_q <= fsm_d;
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (v_i) fsm_d = KEXP;
      KEXP:    if (cnt == 4'd10) fsm_d = DEC;
      DEC:     if (cnt == 4'd0) fsm_d = DONE;
      DONE:    if (ready_i) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Cipher state and round counter
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= '0;
      cnt   <= 4'd0;
    end else begin
      case (fsm_q)
        IDLE: if (v_i) cnt <= 4'd1;
        KEXP: begin
          if (cnt == 4'd10) begin
            state <= ct ^ rk_new;
            cnt   <= 4'd9;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          if (cnt == 4'd0) begin
            state <= round_ark;
          end else begin
            state <= round_full;
            cnt   <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Ciphertext and round-key file; contents after reset are irrelevant
  always_ff @(posedge clk_i) begin
    if (fsm_q == IDLE && v_i) begin
      ct    <= ciphertext_i;
      rk[0] <= key_i;
    end else if (fsm_q == KEXP) begin
      rk[cnt] <= rk_new;
    end
  end

  assign ready_o     = reset_n_i && (fsm_q == IDLE);
  assign v_o         = (fsm_q == DONE);
  assign plaintext_o = state;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb/tb_aes128_decrypt_iter.sv - self-checking bench for aes128_decrypt_iter
module tb_aes128_decrypt_iter;

  logic         clk;
  logic         reset_n;
  logic         v_in;
  logic         ready_out;
  logic [127:0] ct_in;
  logic [127:0] key_in;
  logic         v_out;
  logic         ready_in;
  logic [127:0] pt_out;

  int vectors;
  int miscompares;
  int cyc;

  logic [7:0] sb   [256];
  logic [7:0] isb  [256];
  logic [7:0] gexp [256];
  int         glog [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_decrypt_iter dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v_in),
    .ready_o     (ready_out),
    .ciphertext_i(ct_in),
    .key_i       (key_in),
    .v_o         (v_out),
    .ready_i     (ready_in),
    .plaintext_o (pt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Field multiply through log/antilog tables of generator 3
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = p;
      glog[p] = i;
      p = p ^ xtime(p);
    end
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : gexp[(255 - glog[a]) % 255];
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      end
      sb[a] = s;
    end
    for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
  endtask

  function automatic logic [7:0] imc_coef(input int r, input int k);
    case ((k - r + 4) % 4)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Textbook inverse cipher on a 4x4 byte matrix with a 44-word schedule
  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   acc;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ w[40 + c][31 - 8*r -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][(c + r) % 4] = s[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = isb[t[r][c]] ^ w[4*rd + c][31 - 8*r -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(imc_coef(r, k), s[k][c]);
            t[r][c] = acc;
          end
        end
        s = t;
      end
    end
    out = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127 - 8*(4*c + r) -: 8] = s[r][c];
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [127:0] k, input logic [127:0] c);
    int n;
    n = 0;
    while (ready_out !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_accept", {127'b0, ready_out}, 128'd1);
    key_in = k;
    ct_in  = c;
    v_in   = 1'b1;
    @(posedge clk); #1;
    v_in   = 1'b0;
  endtask

  task automatic wait_vo(output int n);
    n = 0;
    while (v_out !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_txn(input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] exp, input string tag);
    int n;
    ready_in = 1'b1;
    start_txn(k, c);
    wait_vo(n);
    check({tag, "_latency"}, 128'(n), 128'd20);
    check({tag, "_plaintext"}, pt_out, exp);
    @(posedge clk); #1;
    check({tag, "_vo_drop"}, {127'b0, v_out}, 128'd0);
  endtask

  initial begin
    int           n;
    int           t0;
    int           t1;
    int           seen;
    logic [127:0] rk_key;
    logic [127:0] rk_ct;
    logic [127:0] held;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    build_tables();

    reset_n  = 1'b0;
    v_in     = 1'b0;
    ready_in = 1'b1;
    ct_in    = '0;
    key_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {127'b0, ready_out}, 128'd0);
    check("reset_vo", {127'b0, v_out}, 128'd0);
    check("reset_plaintext", pt_out, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", {127'b0, ready_out}, 128'd1);

    run_txn(C1_KEY, C1_CT, C1_PT, "fips_c1");
    run_txn(B_KEY, B_CT, B_PT, "fips_b");
    check("fips_b_rk10", dut.rk[10], B_RK10);
    run_txn(128'd0, Z_CT, 128'd0, "zero_key");

    // Backpressure: result held for 15 cycles while new requests are ignored
    rk_key   = {$urandom, $urandom, $urandom, $urandom};
    rk_ct    = {$urandom, $urandom, $urandom, $urandom};
    ready_in = 1'b0;
    start_txn(rk_key, rk_ct);
    wait_vo(n);
    check("bp_latency", 128'(n), 128'd20);
    check("bp_plaintext", pt_out, ref_decrypt(rk_key, rk_ct));
    held = pt_out;
    for (int i = 0; i < 15; i++) begin
      v_in   = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      ct_in  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("bp_hold_plaintext", pt_out, held);
      check("bp_hold_ready", {127'b0, ready_out}, 128'd0);
      check("bp_hold_vo", {127'b0, v_out}, 128'd1);
    end
    v_in     = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    check("bp_release_vo", {127'b0, v_out}, 128'd0);
    check("bp_release_ready", {127'b0, ready_out}, 128'd1);
    rk_key = {$urandom, $urandom, $urandom, $urandom};
    rk_ct  = {$urandom, $urandom, $urandom, $urandom};
    run_txn(rk_key, rk_ct, ref_decrypt(rk_key, rk_ct), "bp_next");

    // Back-to-back with v_i held high
    ready_in = 1'b1;
    key_in   = C1_KEY;
    ct_in    = C1_CT;
    v_in     = 1'b1;
    @(posedge clk); #1;
    t0     = cyc;
    key_in = B_KEY;
    ct_in  = B_CT;
    wait_vo(n);
    check("b2b_first_latency", 128'(n), 128'd20);
    check("b2b_first_plaintext", pt_out, C1_PT);
    n = 0;
    while (ready_out !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    t1   = cyc;
    v_in = 1'b0;
    check("b2b_interval", 128'(t1 - t0), 128'd22);
    wait_vo(n);
    check("b2b_second_latency", 128'(n), 128'd20);
    check("b2b_second_plaintext", pt_out, B_PT);
    @(posedge clk); #1;

    // Reset in the middle of a transaction
    start_txn(C1_KEY, C1_CT);
    repeat (13) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_vo", {127'b0, v_out}, 128'd0);
    check("midreset_ready_low", {127'b0, ready_out}, 128'd0);
    check("midreset_plaintext", pt_out, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_ready_after", {127'b0, ready_out}, 128'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (v_out !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    check("midreset_no_output", 128'(seen), 128'd0);
    run_txn(C1_KEY, C1_CT, C1_PT, "midreset_fresh");

    // Randomized vectors against the reference model
    for (int i = 0; i < 8; i++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      rk_ct  = {$urandom, $urandom, $urandom, $urandom};
      run_txn(rk_key, rk_ct, ref_decrypt(rk_key, rk_ct), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 decryption core: the inverse-direction counterpart of `encryption_rounds`. It accepts one 128-bit ciphertext and 128-bit cipher key per transaction and runs the on-chip key expansion. It then applies the ten inverse rounds, one per clock, and returns the 128-bit plaintext over a valid/ready handshake. It sits beside the encryption datapath in the AES algorithm chip and uses the same FIPS-197 byte ordering.

## Interface
- No parameters; widths are fixed by AES-128.
- `clk_i` input 1: single clock, all state updates on rising edge.
- `reset_n_i` input 1: one clock; reset is synchronous and active-low.
- `v_i` input 1: ciphertext/key valid.
- `ready_o` output 1: core idle and able to accept.
- `ciphertext_i` input 128: ciphertext, byte 0 = bits [127:120], column-major state (FIPS-197).
- `key_i` input 128: cipher key, same byte order.
- `v_o` output 1: plaintext valid.
- `ready_i` input 1: downstream accepts plaintext.
- `plaintext_o` output 128: decrypted block, same byte order.

## Operation
- Storage: `state` (128 b), `ct` (128 b), round-key file `rk[0..10]` (11×128 b), round counter (4 b), FSM.
- FSM states: IDLE, KEXP, DEC, DONE.
- IDLE: `ready_o`=1. On `v_i && ready_o`, latch `ct`←`ciphertext_i`, `rk[0]`←`key_i`, counter←1, go KEXP.
- KEXP: each cycle compute `rk[i]` from `rk[i-1]` (RotWord, SubWord via forward S-box, Rcon[i] = 01,02,04,08,10,20,40,80,1b,36). Write `rk[i]`, then increment.
  - At i=10, also write `state`←`ct` ^ (new `rk[10]`), counter←9, go DEC.
- DEC, counter r = 9..1: `state` ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(`state`)), `rk[r]`)), then decrement.
- DEC, r = 0: `state` ← InvSubBytes(InvShiftRows(`state`)) ^ `rk[0]` (no InvMixColumns), go DONE.
- DONE: `v_o`=1, `plaintext_o`=`state`. On `ready_i`, go IDLE.
  - `v_o` and `plaintext_o` are held stable until accepted.
- `plaintext_o` always drives `state`; its value is meaningful only while `v_o`=1.
- `v_i`, `ciphertext_i` and `key_i` are ignored outside IDLE.
- No key caching: every transaction re-expands the key.
- S-box and inverse S-box are internal constant tables.
- GF(2^8) arithmetic uses polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09.

## Timing
- Acceptance edge = E0. E1..E10 write `rk[1..10]`. E10 also loads the whitened state. E11..E19 perform full inverse rounds 9..1. E20 performs the final round.
- `v_o` is high from the cycle after E20: 20 cycles after the acceptance edge.
- Earliest next acceptance: one cycle after the `v_o && ready_i` edge, because the core returns to IDLE first. Minimum initiation interval is 22 cycles.
- `ready_o` is combinational from the FSM (IDLE only). It never depends on `v_i`.
- `ready_i` held low: the core stays in DONE indefinitely, and `plaintext_o` does not change.
- Reset (`reset_n_i`=0 at an edge) from any state, including mid-KEXP/DEC:
  - FSM←IDLE, `v_o`=0, `state`=0, counter=0.
  - `rk` and `ct` are don't-care.
  - `ready_o`=0 while `reset_n_i` is low; `ready_o`=1 in the first cycle after release.
  - An aborted transaction produces no output.
- `v_i` asserted in the same cycle as reset release is ignored. Acceptance requires `ready_o`=1 at that edge.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, `v_o` rising exactly 20 cycles after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Also check internal `rk[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> plaintext all-zero.
- Backpressure: hold `ready_i`=0 for 15 cycles after `v_o` -> `plaintext_o` stable, `ready_o`=0, and a new `v_i` is ignored. Then assert `ready_i` -> IDLE next cycle, and the next vector decrypts correctly.
- Back-to-back C.1 then App. B with `v_i` held and `ready_i`=1 -> both correct, with acceptances 22 cycles apart.
- Reset asserted at cycle 14 of a transaction -> `v_o`=0 and no output for that block. `ready_o`=1 the cycle after release, and a fresh C.1 vector decrypts correctly.
